// File: rtl/md_unit32_if.sv
// Bundles the execute-stage multiply/divide signals between the ALU control and md_unit32.
// The master side is the issuing control logic and the slave side is the unit.
interface md_unit32_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Md_op;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Hi_write;
  logic             Lo_write;
  logic [WIDTH-1:0] Write_data;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Md_op, Read_data_1, Read_data_2, Hi_write, Lo_write, Write_data,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Md_op, Read_data_1, Read_data_2, Hi_write, Lo_write, Write_data,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/md_unit32.sv
// Iterative multiply/divide unit with HI/LO registers.
// Each operation runs one latch edge, WIDTH iteration edges and one sign-fix edge.
module md_unit32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  md_unit32_if.slave  md
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_next_s;

  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   orig_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               sgn_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic               div0_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      cond_neg = -v;
    end else begin
      cond_neg = v;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    if (neg) begin
      cond_neg_wide = -v;
    end else begin
      cond_neg_wide = v;
    end
  endfunction

  // Operand conditioning, one iteration step for each algorithm, and the final sign fix.
  always_comb begin
    sgn_op_s = ~md.Md_op[0];
    a_neg_s  = sgn_op_s & md.Read_data_1[WIDTH-1];
    b_neg_s  = sgn_op_s & md.Read_data_2[WIDTH-1];
    a_abs_s  = cond_neg(md.Read_data_1, a_neg_s);
    b_abs_s  = cond_neg(md.Read_data_2, b_neg_s);

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Restoring division: {remainder, quotient} shift left together.
    rem_sh_s = acc_r[2*WIDTH-1:WIDTH-1];
    diff_s   = rem_sh_s - {1'b0, opnd_r};
    if (diff_s[WIDTH]) begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end

    prod_s = cond_neg_wide(acc_r, neg_res_r);
    quo_s  = cond_neg(acc_r[WIDTH-1:0], neg_res_r);
    rem_s  = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
    div0_s = is_div_r & (opnd_r == {WIDTH{1'b0}});

    if (div0_s) begin
      fix_hi_s = orig_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else if (is_div_r) begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Next-state decode for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (md.Start) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_FIX:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      opnd_r    <= {WIDTH{1'b0}};
      orig_r    <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (md.Hi_write) begin
            hi_r <= md.Write_data;
          end
          if (md.Lo_write) begin
            lo_r <= md.Write_data;
          end
          if (md.Start) begin
            // Multiply keeps the multiplicand in opnd_r; divide keeps the divisor there.
            is_div_r  <= md.Md_op[1];
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            orig_r    <= md.Read_data_1;
            cnt_r     <= {CNT_W{1'b0}};
            if (md.Md_op[1]) begin
              opnd_r <= b_abs_s;
              acc_r  <= {{WIDTH{1'b0}}, a_abs_s};
            end else begin
              opnd_r <= a_abs_s;
              acc_r  <= {{WIDTH{1'b0}}, b_abs_s};
            end
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (is_div_r) begin
            acc_r <= div_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
        end
        ST_FIX: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          done_r <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign md.Busy = busy_r;
  assign md.Done = done_r;
  assign md.Hi   = hi_r;
  assign md.Lo   = lo_r;

endmodule

// File: tb/tb_md_unit32.sv
// Self-checking bench for md_unit32: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_md_unit32;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_mis;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  md_unit32_if #(.WIDTH(32)) mdi ();

  md_unit32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .md    (mdi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: full-precision arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int collide_at, input logic wr_start);
    logic [63:0] exp;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          bad;
    exp = model(op, a, b);
    @(negedge clock);
    mdi.Start       = 1'b1;
    mdi.Md_op       = op;
    mdi.Read_data_1 = a;
    mdi.Read_data_2 = b;
    if (wr_start) begin
      mdi.Hi_write   = 1'b1;
      mdi.Lo_write   = 1'b1;
      mdi.Write_data = $urandom;
      ref_hi = mdi.Write_data;
      ref_lo = mdi.Write_data;
    end
    @(posedge clock);
    @(negedge clock);
    mdi.Start       = 1'b0;
    mdi.Hi_write    = 1'b0;
    mdi.Lo_write    = 1'b0;
    mdi.Read_data_1 = $urandom;
    mdi.Read_data_2 = $urandom;
    mdi.Md_op       = 2'($urandom_range(0, 3));
    pre_hi = ref_hi;
    pre_lo = ref_lo;
    bad = 0;
    for (int e = 1; e <= 33; e++) begin
      if (mdi.Busy !== 1'b1 || mdi.Done !== 1'b0 || mdi.Hi !== pre_hi || mdi.Lo !== pre_lo) bad++;
      if (e == collide_at) begin
        mdi.Start       = 1'b1;
        mdi.Hi_write    = 1'b1;
        mdi.Write_data  = 32'h0000_DEAD;
        mdi.Read_data_1 = $urandom;
        mdi.Read_data_2 = $urandom;
      end
      @(posedge clock);
      @(negedge clock);
      if (e == collide_at) begin
        mdi.Start    = 1'b0;
        mdi.Hi_write = 1'b0;
      end
    end
    chk("busy_window", 32'(bad), 32'd0);
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
    chk("done_at_e33", {31'd0, mdi.Done}, 32'd1);
    chk("busy_at_e33", {31'd0, mdi.Busy}, 32'd0);
    chk("hi_result", mdi.Hi, ref_hi);
    chk("lo_result", mdi.Lo, ref_lo);
    @(posedge clock);
    @(negedge clock);
    chk("done_at_e34", {31'd0, mdi.Done}, 32'd0);
  endtask

  task automatic no_done(input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clock);
      if (mdi.Done !== 1'b0 || mdi.Busy !== 1'b0) bad++;
    end
    chk("no_extra_done", 32'(bad), 32'd0);
  endtask

  task automatic wr_both(input logic [31:0] w);
    @(negedge clock);
    mdi.Hi_write   = 1'b1;
    mdi.Lo_write   = 1'b1;
    mdi.Write_data = w;
    @(posedge clock);
    @(negedge clock);
    mdi.Hi_write = 1'b0;
    mdi.Lo_write = 1'b0;
    ref_hi = w;
    ref_lo = w;
    chk("mthi_both", mdi.Hi, ref_hi);
    chk("mtlo_both", mdi.Lo, ref_lo);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    mdi.Start       = 1'b0;
    mdi.Md_op       = 2'b00;
    mdi.Read_data_1 = 32'd0;
    mdi.Read_data_2 = 32'd0;
    mdi.Hi_write    = 1'b0;
    mdi.Lo_write    = 1'b0;
    mdi.Write_data  = 32'd0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    repeat (2) @(negedge clock);
    chk("reset_hi", mdi.Hi, 32'd0);
    chk("reset_lo", mdi.Lo, 32'd0);
    chk("reset_busy", {31'd0, mdi.Busy}, 32'd0);
    chk("reset_done", {31'd0, mdi.Done}, 32'd0);
    reset = 1'b0;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    chk("multu_max_hi", ref_hi, 32'hFFFF_FFFE);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'b11, 32'd12345, 32'd0, 0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);

    // Start and mthi landing mid-operation must both be dropped.
    do_op(2'b00, 32'd5, 32'd6, 10, 1'b0);
    no_done(40);

    wr_both(32'hA5A5_0F0F);
    do_op(2'b01, 32'd1000, 32'd3000, 0, 1'b1);

    // Reset in the middle of a divide.
    @(negedge clock);
    mdi.Start       = 1'b1;
    mdi.Md_op       = 2'b10;
    mdi.Read_data_1 = 32'hFFFF_FF9C;
    mdi.Read_data_2 = 32'd3;
    @(posedge clock);
    @(negedge clock);
    mdi.Start = 1'b0;
    repeat (15) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, mdi.Busy}, 32'd0);
    chk("midreset_done", {31'd0, mdi.Done}, 32'd0);
    chk("midreset_hi", mdi.Hi, 32'd0);
    chk("midreset_lo", mdi.Lo, 32'd0);
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    no_done(40);

    @(negedge clock);
    mdi.Lo_write   = 1'b1;
    mdi.Write_data = 32'h0000_1234;
    @(posedge clock);
    @(negedge clock);
    mdi.Lo_write = 1'b0;
    ref_lo = 32'h0000_1234;
    chk("mtlo_lo", mdi.Lo, ref_lo);
    chk("mtlo_hi_kept", mdi.Hi, ref_hi);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_op(op, a, b, 0, 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
